// File: rtl/regfile_wb_arbiter_pkg.sv
// ============================================================================
// Package : regfile_wb_pkg
// Brief   : Shared widths and helpers for the register-file writeback arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_wb_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;
  localparam int MAX_REQ    = 4;

  localparam logic [4:0] ZERO_REG = 5'd0;

  // Index of the set bit; callers guarantee at most one bit is set.
  function automatic int onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_wb_arbiter_rr.sv
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational rotating-priority arbiter; search starts at ptr+1.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt
);

  int   w_idx;
  logic w_found;

  always_comb begin
    gnt     = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 1; k <= N; k++) begin
      w_idx = (int'(ptr) + k) % N;
      if (!w_found && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        w_found    = 1'b1;
      end
    end
    if (!en) gnt = '0;
  end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module  : regfile_wb_arbiter
// Brief   : Round-robin sharing of the register-file write port with one
//           registered write stage, pending-write mask and optional bypass.
//           Optional bypass compare enabled by macro RF_WB_BYPASS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      wb_stall,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  output logic [(2**ADDR_W)-1:0]    pend_mask,
  input  logic [ADDR_W-1:0]         rd_addr1,
  input  logic [ADDR_W-1:0]         rd_addr2,
  output logic                      fwd_hit1,
  output logic                      fwd_hit2,
  output logic [DATA_W-1:0]         fwd_data1,
  output logic [DATA_W-1:0]         fwd_data2
);

  localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

  logic [PTR_W-1:0]   r_ptr;
  logic               r_we;
  logic [ADDR_W-1:0]  r_waddr;
  logic [DATA_W-1:0]  r_wdata;

  logic [ADDR_W-1:0]  w_addr [NUM_REQ];
  logic [DATA_W-1:0]  w_data [NUM_REQ];
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_en;
  logic               w_accept;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_data;
  int                 w_sel_idx;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign w_addr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
      assign w_data[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Reset gates the grant so no handshake can complete while rst_n is low.
  assign w_en = rst_n & ~wb_stall;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req (req_valid),
    .ptr (r_ptr),
    .en  (w_en),
    .gnt (w_gnt)
  );

  assign req_ready = w_gnt;
  assign w_accept  = |(req_valid & w_gnt);
  assign w_sel_idx = onehot_to_idx(MAX_REQ'(w_gnt));

  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_addr = w_addr[i];
        w_sel_data = w_data[i];
      end
    end
  end

  // Writes to the zero register are consumed but never strobed to the file.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_ptr   <= PTR_W'(NUM_REQ - 1);
    end else begin
      r_we <= w_accept && (w_sel_addr != ADDR_W'(ZERO_REG));
      if (w_accept) begin
        r_waddr <= w_sel_addr;
        r_wdata <= w_sel_data;
        r_ptr   <= PTR_W'(w_sel_idx);
      end
    end
  end

  assign rf_we    = r_we;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i]) pend_mask[w_addr[i]] = 1'b1;
    end
    if (r_we) pend_mask[r_waddr] = 1'b1;
    pend_mask[0] = 1'b0;
  end

`ifdef RF_WB_BYPASS_EN
  // Covers the gap between the write stage and the file's combinational read.
  assign fwd_hit1  = r_we && (r_waddr == rd_addr1) && (rd_addr1 != ADDR_W'(ZERO_REG));
  assign fwd_hit2  = r_we && (r_waddr == rd_addr2) && (rd_addr2 != ADDR_W'(ZERO_REG));
  assign fwd_data1 = fwd_hit1 ? r_wdata : '0;
  assign fwd_data2 = fwd_hit2 ? r_wdata : '0;
`else
  logic w_unused_rd;
  assign w_unused_rd = ^{rd_addr1, rd_addr2};
  assign fwd_hit1    = 1'b0;
  assign fwd_hit2    = 1'b0;
  assign fwd_data1   = '0;
  assign fwd_data2   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
// Module  : tb_regfile_wb_arbiter
// Brief   : Directed scoreboard bench for regfile_wb_arbiter (NUM_REQ=2).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;

`ifdef RF_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [9:0]  req_addr;
  logic [63:0] req_data;
  logic [1:0]  req_ready;
  logic        wb_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pend_mask;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [31:0] fwd_data1;
  logic [31:0] fwd_data2;

  int n_vec = 0;
  int n_err = 0;
  logic [36:0] exp_q[$];

  regfile_wb_arbiter #(
    .NUM_REQ (2),
    .ADDR_W  (5),
    .DATA_W  (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wb_stall  (wb_stall),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .pend_mask (pend_mask),
    .rd_addr1  (rd_addr1),
    .rd_addr2  (rd_addr2),
    .fwd_hit1  (fwd_hit1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data1 (fwd_data1),
    .fwd_data2 (fwd_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    req_addr[i*5 +: 5]  = a;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the next expected write in order.
  always @(posedge clk) begin
    logic [36:0] e;
    #1;
    if (rf_we === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL wb_unexpected: got r%0d=%0h, expected no write", rf_waddr, rf_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({rf_waddr, rf_wdata} !== e) begin
          n_err++;
          $display("FAIL wb_write: got r%0d=%0h, expected r%0d=%0h",
                   rf_waddr, rf_wdata, e[36:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    wb_stall  = 1'b0;
    req_valid = 2'b11;
    req_addr  = '0;
    req_data  = '0;
    rd_addr1  = '0;
    rd_addr2  = '0;
    set_req(0, 5'd5, 32'hA);
    set_req(1, 5'd6, 32'hB);

    // Reset with both requesters valid
    repeat (2) step();
    #1;
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_we", rf_we, 1'b0);
    chk("rst_waddr", rf_waddr, 5'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_pend", pend_mask, 32'h0000_0060);
    rst_n = 1'b1;
    #1;
    chk("rst_first_grant", req_ready, 2'b01);
    push(5'd5, 32'hA);

    // Contention alternates grants
    step(); #1;
    chk("cont_grant1", req_ready, 2'b10);
    chk("cont_pend", pend_mask, 32'h0000_0060);
    push(5'd6, 32'hB);
    step(); #1;
    chk("cont_grant0", req_ready, 2'b01);
    req_valid = 2'b01;
    push(5'd5, 32'hA);
    step();

    // Zero register write is consumed but dropped
    req_valid = 2'b10;
    set_req(1, 5'd0, 32'hFFFF_FFFF);
    #1;
    chk("zero_ready", req_ready, 2'b10);
    chk("zero_pend", pend_mask, 32'h0000_0020);
    step();
    req_valid = 2'b00;
    #1;
    chk("zero_we", rf_we, 1'b0);
    chk("zero_pend_after", pend_mask, 32'h0000_0000);

    // Stall: no grants, pointer holds (req0 must win first afterwards)
    wb_stall  = 1'b1;
    req_valid = 2'b11;
    set_req(0, 5'd9, 32'h99);
    set_req(1, 5'd10, 32'h10);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_ready", req_ready, 2'b00);
      step();
    end
    wb_stall = 1'b0;
    #1;
    chk("post_stall_grant0", req_ready, 2'b01);
    push(5'd9, 32'h99);
    step(); #1;
    chk("post_stall_grant1", req_ready, 2'b10);
    push(5'd10, 32'h10);
    step();
    req_valid = 2'b00;

    // Pending mask and bypass
    req_valid = 2'b01;
    set_req(0, 5'd7, 32'h1234);
    push(5'd7, 32'h1234);
    step();
    req_valid = 2'b00;
    rd_addr1  = 5'd7;
    rd_addr2  = 5'd5;
    #1;
    chk("pend_r7", pend_mask, 32'h0000_0080);
    chk("fwd_hit1", fwd_hit1, BYP);
    chk("fwd_data1", fwd_data1, BYP ? 32'h1234 : 32'h0);
    chk("fwd_hit2", fwd_hit2, 1'b0);
    chk("fwd_data2", fwd_data2, 32'h0);
    step();

    // Reset the cycle after an accept
    req_valid = 2'b01;
    set_req(0, 5'd12, 32'hC);
    #1;
    chk("midrst_grant", req_ready, 2'b01);
    push(5'd12, 32'hC);
    step();
    rst_n = 1'b0;
    set_req(0, 5'd13, 32'hD);
    #1;
    chk("midrst_ready", req_ready, 2'b00);
    step(); #1;
    chk("midrst_we", rf_we, 1'b0);
    chk("midrst_waddr", rf_waddr, 5'd0);
    rst_n     = 1'b1;
    req_valid = 2'b00;
    repeat (3) step();
    chk("sb_drain", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
